// File: rtl/axi_aw_arbiter.sv
// rtl/axi_aw_arbiter.sv - round-robin AXI AW arbiter with W-route FIFO
// Optional outstanding-write cap enabled by defining AXI_AW_ARB_OUTSTANDING_LIMIT_EN.
module axi_aw_arbiter #(
  parameter int N_SLAVES        = 4,
  parameter int AW_WIDTH        = 75,
  parameter int WFIFO_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_SLAVES-1:0]           slave_valid_i,
  input  logic [N_SLAVES*AW_WIDTH-1:0]  slave_aw_i,
  output logic [N_SLAVES-1:0]           slave_ready_o,
  output logic                          master_valid_o,
  output logic [AW_WIDTH-1:0]           master_aw_o,
  input  logic                          master_ready_i,
  output logic [$clog2(N_SLAVES)-1:0]   w_sel_o,
  output logic                          w_sel_valid_o,
  input  logic                          w_sel_pop_i,
  input  logic                          b_done_i
);

  localparam int IDX_W = $clog2(N_SLAVES);
  localparam int PTR_W = $clog2(WFIFO_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d, grant_q, grant_d;
  logic [IDX_W-1:0] mem_q [WFIFO_DEPTH];
  logic [IDX_W-1:0] mem_d [WFIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] winner, sel;
  logic             found, hs, push, pop, blocked, fifo_full, fifo_empty;

  assign fifo_full  = (occ_q == (PTR_W+1)'(WFIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);

`ifdef AXI_AW_ARB_OUTSTANDING_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  logic [CNT_W-1:0] count_q, count_d;
  logic             dec;

  always_comb begin
    dec     = b_done_i && (count_q != '0);
    count_d = count_q;
    if (hs && !dec)      count_d = count_q + CNT_W'(1);
    else if (!hs && dec) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign blocked = fifo_full || (count_q == CNT_W'(MAX_OUTSTANDING));
`else
  logic unused_b_done;
  assign unused_b_done = b_done_i;
  assign blocked       = fifo_full;
`endif

  // Rotating priority scan starting at rr_q.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_SLAVES)) cand = cand - (IDX_W+1)'(N_SLAVES);
      if (!found && slave_valid_i[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  // Outputs are forced quiet while reset is asserted so no handshake can slip through.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_d           = rr_q;
    sel            = grant_q;
    master_valid_o = 1'b0;
    slave_ready_o  = '0;
    hs             = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          if (!blocked && found) begin
            sel                   = winner;
            master_valid_o        = 1'b1;
            slave_ready_o[winner] = master_ready_i;
            if (master_ready_i) begin
              hs = 1'b1;
            end else begin
              grant_d = winner;
              state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          master_valid_o         = slave_valid_i[grant_q];
          slave_ready_o[grant_q] = master_ready_i;
          if (slave_valid_i[grant_q] && master_ready_i) begin
            hs      = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (hs) rr_d = (sel == IDX_W'(N_SLAVES - 1)) ? '0 : sel + IDX_W'(1);
  end

  always_comb begin
    master_aw_o = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel == IDX_W'(k)) master_aw_o = slave_aw_i[k*AW_WIDTH +: AW_WIDTH];
    end
  end

  assign push = hs;
  assign pop  = w_sel_pop_i && !fifo_empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = sel;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      occ_d = occ_q + (PTR_W+1)'(1);
    else if (!push && pop) occ_d = occ_q - (PTR_W+1)'(1);
  end

  assign w_sel_valid_o = !fifo_empty;
  assign w_sel_o       = fifo_empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int k = 0; k < WFIFO_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_axi_aw_arbiter.sv
// tb/tb_axi_aw_arbiter.sv - self-checking bench for axi_aw_arbiter
module tb_axi_aw_arbiter;
  localparam int N = 4, AWW = 75, DEPTH = 4;
`ifdef AXI_AW_ARB_OUTSTANDING_LIMIT_EN
  localparam int MAXO = 2;
`else
  localparam int MAXO = 8;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    slave_valid, slave_ready;
  logic [N*AWW-1:0] slave_aw;
  logic            master_valid, master_ready;
  logic [AWW-1:0]  master_aw;
  logic [1:0]      w_sel;
  logic            w_sel_valid, w_sel_pop, b_done;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_q[$];
  int wsel_q[$];

  always #5 clk = ~clk;

  axi_aw_arbiter #(.N_SLAVES(N), .AW_WIDTH(AWW), .WFIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .slave_valid_i(slave_valid), .slave_aw_i(slave_aw),
    .slave_ready_o(slave_ready), .master_valid_o(master_valid), .master_aw_o(master_aw),
    .master_ready_i(master_ready), .w_sel_o(w_sel), .w_sel_valid_o(w_sel_valid),
    .w_sel_pop_i(w_sel_pop), .b_done_i(b_done)
  );

  function automatic logic [AWW-1:0] pay(int k);
    return {11'(k), 32'hC0DE_0000 + 32'(k * 7), 32'(k) ^ 32'h5A5A_5A5A};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; slave_valid = '0; master_ready = 1'b0; w_sel_pop = 1'b0; b_done = 1'b0;
    exp_q.delete(); wsel_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; slave_valid = '1; master_ready = 1'b1; w_sel_pop = 1'b0; b_done = 1'b0;
    #1;
    vec_cnt++; if (master_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_mvalid got %0b want 0", master_valid); end
    vec_cnt++; if (slave_ready !== 4'b0) begin err_cnt++; $display("FAIL reset_sready got %b want 0000", slave_ready); end
    vec_cnt++; if (w_sel_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_wvalid got %0b want 0", w_sel_valid); end
    vec_cnt++; if (w_sel !== 2'd0) begin err_cnt++; $display("FAIL reset_wsel got %0d want 0", w_sel); end
    slave_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    vec_cnt++; if (master_valid !== 1'b0) begin err_cnt++; $display("FAIL idle_mvalid got %0b want 0", master_valid); end
  endtask

  task automatic test_round_robin();
    int e, pops;
    do_reset();
    exp_q = '{0, 1, 2, 3, 0};
    pops = 0;
    slave_valid = '1; master_ready = 1'b1; w_sel_pop = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (!(master_valid && master_ready) || exp_q.size() == 0) begin
        err_cnt++; $display("FAIL rr_hs cycle %0d got valid %0b want 1", c, master_valid);
      end else begin
        e = exp_q.pop_front();
        if (slave_ready !== 4'(1 << e) || master_aw !== pay(e)) begin
          err_cnt++; $display("FAIL rr_grant cycle %0d got ready %b want %b", c, slave_ready, 4'(1 << e));
        end
        wsel_q.push_back(e);
      end
      if (w_sel_valid && wsel_q.size() > 0) begin
        e = wsel_q.pop_front(); pops++;
        vec_cnt++; if (w_sel !== 2'(e)) begin err_cnt++; $display("FAIL rr_wsel got %0d want %0d", w_sel, e); end
      end
      next_cycle();
    end
    vec_cnt++; if (pops !== 4) begin err_cnt++; $display("FAIL rr_wsel_count got %0d want 4", pops); end
    slave_valid = '0;
  endtask

  task automatic test_rr_pointer();
    logic [3:0] tv [5] = '{4'b0010, 4'b1001, 4'b1001, 4'b1001, 4'b0110};
    int         te [5] = '{1, 3, 0, 3, 1};
    int e;
    do_reset();
    master_ready = 1'b1; w_sel_pop = 1'b1;
    for (int c = 0; c < 5; c++) begin
      slave_valid = tv[c];
      exp_q.push_back(te[c]);
      @(negedge clk);
      e = exp_q.pop_front();
      vec_cnt++;
      if (slave_ready !== 4'(1 << e) || master_aw !== pay(e)) begin
        err_cnt++; $display("FAIL rr_ptr step %0d got ready %b want %b", c, slave_ready, 4'(1 << e));
      end
      next_cycle();
    end
    slave_valid = '0;
  endtask

  task automatic test_locked();
    logic [3:0] tv [5] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0001};
    logic       tr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int         ta [5] = '{1, 1, 1, 1, 0};
    logic [3:0] ts [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
    do_reset();
    w_sel_pop = 1'b1;
    for (int c = 0; c < 5; c++) begin
      slave_valid = tv[c]; master_ready = tr[c];
      @(negedge clk);
      vec_cnt++;
      if (master_valid !== 1'b1 || master_aw !== pay(ta[c]) || slave_ready !== ts[c]) begin
        err_cnt++;
        $display("FAIL locked step %0d got valid %0b id %0d ready %b want 1 %0d %b", c, master_valid, master_aw[74:64], slave_ready, ta[c], ts[c]);
      end
      next_cycle();
    end
    slave_valid = '0;
  endtask

  task automatic test_fifo_full();
    int hs_cnt, e;
    do_reset();
    hs_cnt = 0;
    slave_valid = '1; master_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (master_valid && master_ready) hs_cnt++;
      next_cycle();
    end
    vec_cnt++; if (hs_cnt !== 4) begin err_cnt++; $display("FAIL full_hs got %0d want 4", hs_cnt); end
    @(negedge clk);
    vec_cnt++; if (master_valid !== 1'b0) begin err_cnt++; $display("FAIL full_stall got %0b want 0", master_valid); end
    vec_cnt++; if (w_sel_valid !== 1'b1 || w_sel !== 2'd0) begin err_cnt++; $display("FAIL full_head got %0b/%0d want 1/0", w_sel_valid, w_sel); end
    next_cycle();
    w_sel_pop = 1'b1;
    @(negedge clk);
    vec_cnt++; if (master_valid !== 1'b0) begin err_cnt++; $display("FAIL pop_cycle_mvalid got %0b want 0", master_valid); end
    next_cycle();
    w_sel_pop = 1'b0;
    @(negedge clk);
    vec_cnt++; if (master_valid !== 1'b1 || slave_ready !== 4'b0001) begin err_cnt++; $display("FAIL after_pop got %0b/%b want 1/0001", master_valid, slave_ready); end
    next_cycle();
    @(negedge clk);
    vec_cnt++; if (master_valid !== 1'b0) begin err_cnt++; $display("FAIL refull got %0b want 0", master_valid); end
    next_cycle();
    slave_valid = '0; w_sel_pop = 1'b1;
    wsel_q = '{1, 2, 3, 0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = wsel_q.pop_front();
      vec_cnt++; if (w_sel_valid !== 1'b1 || w_sel !== 2'(e)) begin err_cnt++; $display("FAIL drain %0d got %0b/%0d want 1/%0d", c, w_sel_valid, w_sel, e); end
      next_cycle();
    end
    vec_cnt++; if (w_sel_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_empty got %0b want 0", w_sel_valid); end
  endtask

  task automatic test_outstanding();
    logic tb [10] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 0};
`ifdef AXI_AW_ARB_OUTSTANDING_LIMIT_EN
    logic tm [10] = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 0};
`else
    logic tm [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    do_reset();
    slave_valid = '1; master_ready = 1'b1; w_sel_pop = 1'b1;
    for (int c = 0; c < 10; c++) begin
      b_done = tb[c];
      @(negedge clk);
      vec_cnt++; if (master_valid !== tm[c]) begin err_cnt++; $display("FAIL outstanding step %0d got %0b want %0b", c, master_valid, tm[c]); end
      next_cycle();
    end
    b_done = 1'b0; slave_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    slave_valid = '1; master_ready = 1'b1;
    next_cycle();
    next_cycle();
    master_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    vec_cnt++; if (master_valid !== 1'b1 || w_sel_valid !== 1'b1) begin err_cnt++; $display("FAIL pre_reset got %0b/%0b want 1/1", master_valid, w_sel_valid); end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if (master_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_mvalid got %0b want 0", master_valid); end
    vec_cnt++; if (w_sel_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_wvalid got %0b want 0", w_sel_valid); end
    master_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    #1;
    vec_cnt++; if (slave_ready !== 4'b0001 || master_aw !== pay(0)) begin err_cnt++; $display("FAIL post_reset_grant got %b want 0001", slave_ready); end
    next_cycle();
    slave_valid = '0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) slave_aw[k*AWW +: AWW] = pay(k);
    test_reset();
    test_round_robin();
    test_rr_pointer();
    test_locked();
    test_fifo_full();
    test_outstanding();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
